// File: rtl/fp_mul_pkg.sv
// Shared constants and state encoding for the single-precision multiply path.
package fp_mul_pkg;

    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    // Canonical quiet NaN returned for every invalid operation.
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    // Exponent/fraction field of an infinity; the sign is prepended by the user.
    localparam logic [30:0] INF_MAG = {8'hFF, 23'h0};

    // Five states need three bits; the sequence is strictly linear.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EXP   = 3'd1,
        ST_NORM  = 3'd2,
        ST_ROUND = 3'd3,
        ST_PACK  = 3'd4
    } state_e;

endpackage

// File: rtl/fp_rne_round.sv
// Round-to-nearest-even on a W-bit mantissa with guard and sticky bits.
// A carry out of the top bit renormalises the mantissa to 1.000...; the
// caller bumps its exponent when carry is set.
module fp_rne_round #(
    parameter int W = 24
) (
    input  logic [W-1:0] m,
    input  logic         g,
    input  logic         st,
    output logic [W-1:0] m_out,
    output logic         carry
);

    logic         rup;
    logic [W:0]   m_sum;

    // Increment on above-half, or on exact half when the LSB is odd.
    always_comb begin
        rup   = g & (st | m[0]);
        m_sum = {1'b0, m} + {{W{1'b0}}, rup};
        carry = m_sum[W];
        m_out = carry ? m_sum[W:1] : m_sum[W-1:0];
    end

endmodule

// File: rtl/fp_norm_round.sv
// Normalise / round / pack stage of the binary32 multiplier. Fixed five-cycle
// walk IDLE->EXP->NORM->ROUND->PACK for every operation, specials included.
module fp_norm_round #(
    parameter int BIAS   = fp_mul_pkg::BIAS,
    parameter int EXP_W  = 8,
    parameter int MANT_W = 24
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      sign_a,
    input  logic                      sign_b,
    input  logic [EXP_W-1:0]          exp_a,
    input  logic [EXP_W-1:0]          exp_b,
    input  logic                      frac_nz_a,
    input  logic                      frac_nz_b,
    input  logic [2*MANT_W-1:0]       product,
    output logic                      busy,
    output logic                      done,
    output logic [EXP_W+MANT_W-1:0]   result
);

    import fp_mul_pkg::*;

    localparam int PW = 2 * MANT_W;     // product width
    localparam int EW = EXP_W + 2;      // signed working exponent, never wraps
    localparam int RW = EXP_W + MANT_W; // packed result width

    localparam logic [EXP_W-1:0]     EXP_ONES = EXP_W'(EXP_MAX);
    localparam logic signed [EW-1:0] E_MAX    = EW'(EXP_MAX);

    state_e                 state_q, state_d;
    logic                   sign_a_q, sign_a_d;
    logic                   sign_b_q, sign_b_d;
    logic [EXP_W-1:0]       exp_a_q, exp_a_d;
    logic [EXP_W-1:0]       exp_b_q, exp_b_d;
    logic                   frac_nz_a_q, frac_nz_a_d;
    logic                   frac_nz_b_q, frac_nz_b_d;
    logic [PW-1:0]          prod_q, prod_d;
    logic signed [EW-1:0]   e_q, e_d;
    logic                   s_q, s_d;
    logic                   nan_q, nan_d;
    logic                   inf_q, inf_d;
    logic                   zero_q, zero_d;
    logic [MANT_W-1:0]      m_q, m_d;
    logic                   g_q, g_d;
    logic                   st_q, st_d;
    logic [RW-1:0]          result_q, result_d;
    logic                   done_q, done_d;

    logic [MANT_W-1:0]      rnd_m;
    logic                   rnd_carry;
    logic                   inf_a, inf_b, zero_a, zero_b, snan_a, snan_b;

    fp_rne_round #(.W(MANT_W)) u_rne (
        .m     (m_q),
        .g     (g_q),
        .st    (st_q),
        .m_out (rnd_m),
        .carry (rnd_carry)
    );

    // Operand classification from the captured exponent/fraction flags.
    always_comb begin
        snan_a = (exp_a_q == EXP_ONES) &  frac_nz_a_q;
        snan_b = (exp_b_q == EXP_ONES) &  frac_nz_b_q;
        inf_a  = (exp_a_q == EXP_ONES) & ~frac_nz_a_q;
        inf_b  = (exp_b_q == EXP_ONES) & ~frac_nz_b_q;
        zero_a = (exp_a_q == '0);
        zero_b = (exp_b_q == '0);
    end

    // Next-state and datapath: each state advances exactly one step.
    always_comb begin
        // NOTE: every _d starts from its _q (or a fixed value), so no branch
        // can leave a signal unassigned and infer a latch.
        state_d     = state_q;
        sign_a_d    = sign_a_q;
        sign_b_d    = sign_b_q;
        exp_a_d     = exp_a_q;
        exp_b_d     = exp_b_q;
        frac_nz_a_d = frac_nz_a_q;
        frac_nz_b_d = frac_nz_b_q;
        prod_d      = prod_q;
        e_d         = e_q;
        s_d         = s_q;
        nan_d       = nan_q;
        inf_d       = inf_q;
        zero_d      = zero_q;
        m_d         = m_q;
        g_d         = g_q;
        st_d        = st_q;
        result_d    = result_q;
        done_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sign_a_d    = sign_a;
                    sign_b_d    = sign_b;
                    exp_a_d     = exp_a;
                    exp_b_d     = exp_b;
                    frac_nz_a_d = frac_nz_a;
                    frac_nz_b_d = frac_nz_b;
                    prod_d      = product;
                    state_d     = ST_EXP;
                end
            end

            ST_EXP: begin
                e_d     = EW'(exp_a_q) + EW'(exp_b_q) - EW'(BIAS);
                s_d     = sign_a_q ^ sign_b_q;
                nan_d   = snan_a | snan_b | (inf_a & zero_b) | (zero_a & inf_b);
                inf_d   = (inf_a | inf_b) & ~nan_d;
                zero_d  = zero_a | zero_b;
                state_d = ST_NORM;
            end

            ST_NORM: begin
                if (prod_q[PW-1]) begin
                    // Product in [2,4): take the top MANT_W bits, bump exponent.
                    m_d  = prod_q[PW-1 -: MANT_W];
                    g_d  = prod_q[PW-MANT_W-1];
                    st_d = |prod_q[PW-MANT_W-2:0];
                    e_d  = e_q + EW'(1);
                end else begin
                    m_d  = prod_q[PW-2 -: MANT_W];
                    g_d  = prod_q[PW-MANT_W-2];
                    st_d = |prod_q[PW-MANT_W-3:0];
                end
                state_d = ST_ROUND;
            end

            ST_ROUND: begin
                m_d = rnd_m;
                if (rnd_carry) begin
                    e_d = e_q + EW'(1);
                end
                state_d = ST_PACK;
            end

            ST_PACK: begin
                if (nan_q) begin
                    result_d = QNAN;
                end else if (inf_q) begin
                    result_d = {s_q, INF_MAG};
                end else if (zero_q) begin
                    result_d = {s_q, (RW-1)'(0)};
                end else if (e_q >= E_MAX) begin
                    result_d = {s_q, INF_MAG};
                end else if (e_q[EW-1] || (e_q == '0)) begin
                    result_d = {s_q, (RW-1)'(0)};
                end else begin
                    result_d = {s_q, e_q[EXP_W-1:0], m_q[MANT_W-2:0]};
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State register; synchronous reset discards any operation in flight.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q     <= ST_IDLE;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            exp_a_q     <= '0;
            exp_b_q     <= '0;
            frac_nz_a_q <= 1'b0;
            frac_nz_b_q <= 1'b0;
            prod_q      <= '0;
            e_q         <= '0;
            s_q         <= 1'b0;
            nan_q       <= 1'b0;
            inf_q       <= 1'b0;
            zero_q      <= 1'b0;
            m_q         <= '0;
            g_q         <= 1'b0;
            st_q        <= 1'b0;
            result_q    <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_a_q    <= sign_a_d;
            sign_b_q    <= sign_b_d;
            exp_a_q     <= exp_a_d;
            exp_b_q     <= exp_b_d;
            frac_nz_a_q <= frac_nz_a_d;
            frac_nz_b_q <= frac_nz_b_d;
            prod_q      <= prod_d;
            e_q         <= e_d;
            s_q         <= s_d;
            nan_q       <= nan_d;
            inf_q       <= inf_d;
            zero_q      <= zero_d;
            m_q         <= m_d;
            g_q         <= g_d;
            st_q        <= st_d;
            result_q    <= result_d;
            done_q      <= done_d;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_fp_norm_round.sv
// Self-checking bench for fp_norm_round: directed corner cases, control
// behaviour and random operands against an arithmetic reference model.
module tb_fp_norm_round;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        sign_a, sign_b;
    logic [7:0]  exp_a, exp_b;
    logic        frac_nz_a, frac_nz_b;
    logic [47:0] product;
    logic        busy, done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    fp_norm_round dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .sign_a    (sign_a),
        .sign_b    (sign_b),
        .exp_a     (exp_a),
        .exp_b     (exp_b),
        .frac_nz_a (frac_nz_a),
        .frac_nz_b (frac_nz_b),
        .product   (product),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    // Safety net: the run is fixed-length, so this only fires on a broken bench.
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %08h, expected %08h", tag, obs, expv);
        end
    endtask

    // Reference: exact integer value of the product, rounded to 24 significant
    // bits by remainder comparison, then classified against the format limits.
    function automatic logic [31:0] ref_mul(input logic sa, input logic sb,
                                            input logic [7:0] ea, input logic [7:0] eb,
                                            input logic na, input logic nb,
                                            input logic [47:0] p);
        logic s;
        bit nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
        int e, sh;
        longint unsigned pv, mant, rem, half;
        s      = sa ^ sb;
        nan_a  = (ea == 8'd255) && na;
        nan_b  = (eb == 8'd255) && nb;
        inf_a  = (ea == 8'd255) && !na;
        inf_b  = (eb == 8'd255) && !nb;
        zero_a = (ea == 8'd0);
        zero_b = (eb == 8'd0);
        if (nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b)) return 32'h7FC00000;
        if (inf_a || inf_b) return {s, 8'hFF, 23'd0};
        if (zero_a || zero_b) return {s, 31'd0};
        e  = int'(ea) + int'(eb) - 127;
        pv = 64'(p);
        // Value = p * 2^-46; keep the 24 bits below and including the leading one.
        if (pv >= (64'd1 << 47)) begin
            sh = 24;
            e  = e + 1;
        end else begin
            sh = 23;
        end
        mant = pv >> sh;
        rem  = pv - (mant << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && mant[0])) mant = mant + 1;
        if (mant == (64'd1 << 24)) begin
            mant = mant >> 1;
            e    = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, e[7:0], mant[22:0]};
    endfunction

    task automatic scramble();
        sign_a    = 1'($urandom);
        sign_b    = 1'($urandom);
        exp_a     = 8'($urandom);
        exp_b     = 8'($urandom);
        frac_nz_a = 1'($urandom);
        frac_nz_b = 1'($urandom);
        product   = 48'({$urandom, $urandom});
    endtask

    task automatic drive(input logic sa, input logic sb, input logic [7:0] ea,
                         input logic [7:0] eb, input logic na, input logic nb,
                         input logic [47:0] p);
        sign_a    = sa;
        sign_b    = sb;
        exp_a     = ea;
        exp_b     = eb;
        frac_nz_a = na;
        frac_nz_b = nb;
        product   = p;
    endtask

    // One operation: checks idle, four busy cycles, then the done cycle.
    task automatic run_op(input string tag, input logic sa, input logic sb,
                          input logic [7:0] ea, input logic [7:0] eb,
                          input logic na, input logic nb, input logic [47:0] p);
        logic [31:0] expv;
        expv = ref_mul(sa, sb, ea, eb, na, nb, p);
        @(negedge clk);
        check({tag, "/idle"}, {30'd0, busy, done}, 32'd0);
        drive(sa, sb, ea, eb, na, nb, p);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        scramble();
        repeat (4) begin
            @(negedge clk);
            check({tag, "/busy"}, {30'd0, busy, done}, 32'd2);
        end
        @(negedge clk);
        check({tag, "/done"}, {30'd0, busy, done}, 32'd1);
        check({tag, "/result"}, result, expv);
    endtask

    function automatic logic [7:0] pick_exp();
        int r;
        r = $urandom_range(0, 15);
        if (r == 0) return 8'd0;
        if (r == 1) return 8'd255;
        if (r < 10) return 8'($urandom_range(64, 190));
        return 8'($urandom_range(1, 254));
    endfunction

    logic [23:0] ma, mb;
    logic [31:0] exp_a_res, exp_b_res;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        drive(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 48'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset/ctrl", {30'd0, busy, done}, 32'd0);
        check("reset/result", result, 32'h0);
        reset = 1'b0;

        // Directed cases with hand-derived expectations.
        run_op("1p5sq", 0, 0, 8'd127, 8'd127, 0, 0, 48'h900000000000);
        check("1p5sq/value", result, 32'h40100000);
        run_op("tie_even", 0, 0, 8'd127, 8'd127, 0, 0, 48'h400000400000);
        check("tie_even/value", result, 32'h3F800000);
        run_op("tie_odd", 0, 0, 8'd127, 8'd127, 0, 0, 48'h400000C00000);
        check("tie_odd/value", result, 32'h3F800002);
        run_op("carry", 0, 0, 8'd127, 8'd127, 0, 0, 48'h7FFFFFC00000);
        check("carry/value", result, 32'h40000000);
        run_op("ovf", 1, 0, 8'd200, 8'd200, 0, 0, 48'h400000000000);
        check("ovf/value", result, 32'hFF800000);
        run_op("unf", 0, 0, 8'd20, 8'd20, 0, 0, 48'h400000000000);
        check("unf/value", result, 32'h00000000);
        run_op("inf_x_zero", 0, 0, 8'd255, 8'd0, 0, 0, 48'h400000000000);
        check("inf_x_zero/value", result, 32'h7FC00000);
        run_op("nan_in", 1, 0, 8'd255, 8'd100, 1, 0, 48'h500000000000);
        check("nan_in/value", result, 32'h7FC00000);
        run_op("zero_in", 1, 0, 8'd0, 8'd130, 0, 0, 48'h600000000000);
        check("zero_in/value", result, 32'h80000000);
        run_op("inf_in", 0, 1, 8'd130, 8'd255, 0, 0, 48'h600000000000);
        check("inf_in/value", result, 32'hFF800000);
        run_op("e_254", 0, 0, 8'd254, 8'd127, 0, 0, 48'h400000000000);
        check("e_254/value", result, 32'h7F000000);
        run_op("e_255", 0, 0, 8'd254, 8'd127, 0, 0, 48'h7FFFFFC00000);
        check("e_255/value", result, 32'h7F800000);
        run_op("e_1", 0, 0, 8'd1, 8'd127, 0, 0, 48'h400000000000);
        check("e_1/value", result, 32'h00800000);
        run_op("e_0", 1, 1, 8'd1, 8'd126, 0, 0, 48'h7FFFFE000000);
        check("e_0/value", result, 32'h00000000);

        // start held high throughout: the first capture wins, the re-assert
        // during busy is ignored, and a fresh capture happens right after done.
        ma = {1'b1, 23'($urandom)};
        mb = {1'b1, 23'($urandom)};
        exp_a_res = ref_mul(1, 0, 8'd128, 8'd126, 0, 0, 48'(ma) * 48'(mb));
        exp_b_res = ref_mul(0, 0, 8'd140, 8'd100, 0, 0, 48'h5A5A5A5A5A5A);
        @(negedge clk);
        check("hold/idle", {30'd0, busy, done}, 32'd0);
        drive(1, 0, 8'd128, 8'd126, 0, 0, 48'(ma) * 48'(mb));
        start = 1'b1;
        @(posedge clk);
        repeat (4) begin
            #1 scramble();
            @(negedge clk);
            check("hold/busy_a", {30'd0, busy, done}, 32'd2);
        end
        @(negedge clk);
        check("hold/done_a", {30'd0, busy, done}, 32'd1);
        check("hold/result_a", result, exp_a_res);
        drive(0, 0, 8'd140, 8'd100, 0, 0, 48'h5A5A5A5A5A5A);
        @(posedge clk);
        repeat (4) begin
            #1 scramble();
            @(negedge clk);
            check("hold/busy_b", {30'd0, busy, done}, 32'd2);
        end
        @(negedge clk);
        check("hold/done_b", {30'd0, busy, done}, 32'd1);
        check("hold/result_b", result, exp_b_res);
        start = 1'b0;

        // Reset while the operation sits in ROUND.
        @(negedge clk);
        drive(0, 0, 8'd127, 8'd127, 0, 0, 48'h900000000000);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid/ctrl", {30'd0, busy, done}, 32'd0);
        check("rst_mid/result", result, 32'h0);
        reset = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("rst_mid/no_done", {30'd0, busy, done}, 32'd0);
        end
        check("rst_mid/result_hold", result, 32'h0);
        run_op("recover", 0, 1, 8'd127, 8'd127, 0, 0, 48'h900000000000);
        check("recover/value", result, 32'hC0100000);

        // Random operands: products of genuine 24-bit mantissas.
        for (int i = 0; i < 40; i++) begin
            ma = {1'b1, 23'($urandom)};
            mb = {1'b1, 23'($urandom)};
            run_op("rand", 1'($urandom), 1'($urandom), pick_exp(), pick_exp(),
                   1'($urandom), 1'($urandom), 48'(ma) * 48'(mb));
        end

        @(negedge clk);
        check("final/idle", {30'd0, busy, done}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
